// File: rtl/csc_ws.sv
// Chip-select and PHI2 generator for a 65816 bus with per-region wait states.
// Optional external wait input (EXT_WAITB) enabled by defining CSC_EXTWAIT_EN.
module csc_ws #(
  parameter int CLK_DIV  = 4,
  parameter int IO_SLOTS = 4,
  parameter int ROM_WAIT = 2,
  parameter int IO_WAIT  = 1,
  parameter int RAM_WAIT = 0
) (
  input  logic                SYSCLK,
  input  logic                RESET,
`ifdef CSC_EXTWAIT_EN
  input  logic                EXT_WAITB,
`endif
  input  logic [15:0]         ADDR,
  input  logic [7:0]          DB,
  input  logic                RWB,
  input  logic                VDA,
  output logic                RESETB,
  output logic [7:0]          BA,
  output logic                PHI2,
  output logic                RDB,
  output logic                WRB,
  output logic                ROMCSB,
  output logic                RAM1CSB,
  output logic                RAM2CSB,
  output logic [IO_SLOTS-1:0] IOSELB,
  output logic                WAITING
);

  localparam int CW = ($clog2(CLK_DIV) > 4) ? $clog2(CLK_DIV) : 4;
  localparam int SW = $clog2(IO_SLOTS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_STRETCH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wait_len_q, wait_len_d;
  logic          phi2_q, phi2_d;
  logic          waiting_q, waiting_d;
  logic [7:0]    ba_q;
  logic          ext_ok;

  logic          bank0, lowrom, highrom, io, ram1, ram2;
  logic [SW-1:0] slot;
  logic [3:0]    wait_class;
  logic [CW:0]   cnt_inc;
  logic          wait_done;
  logic          unused_addr;

`ifdef CSC_EXTWAIT_EN
  logic [1:0] ext_sync_q;
  always_ff @(posedge SYSCLK) begin
    if (RESET) ext_sync_q <= 2'b11;
    else       ext_sync_q <= {ext_sync_q[0], EXT_WAITB};
  end
  assign ext_ok = ext_sync_q[1];
`else
  assign ext_ok = 1'b1;
`endif

  // Address decode works on the latched bank, so it is valid throughout the high phase.
  assign bank0   = (ba_q == 8'h00);
  assign lowrom  = bank0 && (ADDR[15:11] == 5'b11111);
  assign highrom = (ba_q[7:3] == 5'b11111);
  assign io      = bank0 && (ADDR[15:11] == 5'b11110) && VDA;
  assign ram1    = (ba_q[7:3] == 5'b00000) && !io && !lowrom;
  assign ram2    = (ba_q[7:4] == 4'h0) && ba_q[3];
  assign slot    = ADDR[5 +: SW];
  assign unused_addr = ^ADDR;

  assign wait_class = (lowrom || highrom) ? 4'(ROM_WAIT) :
                      io                  ? 4'(IO_WAIT)  : 4'(RAM_WAIT);

  // Saturating compare lets STRETCH outlast wait_len when held by an external wait.
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign wait_done = (cnt_inc >= {{(CW-3){1'b0}}, wait_len_q});

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q    <= ST_LOW;
      cnt_q      <= '0;
      wait_len_q <= '0;
      phi2_q     <= 1'b0;
      waiting_q  <= 1'b0;
      ba_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_len_q <= wait_len_d;
      phi2_q     <= phi2_d;
      waiting_q  <= waiting_d;
      if (!phi2_q) ba_q <= DB;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_len_d = wait_len_q;
    phi2_d     = phi2_q;
    waiting_d  = waiting_q;
    unique case (state_q)
      ST_LOW: begin
        if (cnt_q == CNT_LAST) begin
          phi2_d     = 1'b1;
          cnt_d      = '0;
          wait_len_d = wait_class;
          state_d    = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (wait_len_q == 4'd0 && ext_ok) begin
            phi2_d  = 1'b0;
            state_d = ST_LOW;
          end else begin
            waiting_d = 1'b1;
            state_d   = ST_STRETCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STRETCH: begin
        if (wait_done && ext_ok) begin
          phi2_d    = 1'b0;
          waiting_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_LOW;
        end else if (!wait_done) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Strobes are also held inactive while RESET is asserted.
  always_comb begin
    RDB     = !(phi2_q && RWB && !RESET);
    WRB     = !(phi2_q && !RWB && !RESET);
    ROMCSB  = !(lowrom || highrom);
    RAM1CSB = !ram1;
    RAM2CSB = !ram2;
  end

  for (genvar gi = 0; gi < IO_SLOTS; gi++) begin : g_iosel
    assign IOSELB[gi] = !(io && (slot == SW'(gi)));
  end

  assign RESETB  = !RESET;
  assign BA      = ba_q;
  assign PHI2    = phi2_q;
  assign WAITING = waiting_q;

endmodule

// File: tb/tb_csc_ws.sv
// Randomised bench for csc_ws against a phase-duration reference model.
module tb_csc_ws;
  localparam int CLK_DIV  = 4;
  localparam int IO_SLOTS = 4;
  localparam int ROM_WAIT = 2;
  localparam int IO_WAIT  = 1;
  localparam int RAM_WAIT = 0;

  logic                SYSCLK = 1'b0;
  logic                RESET  = 1'b1;
  logic [15:0]         ADDR   = 16'h0000;
  logic [7:0]          DB     = 8'h00;
  logic                RWB    = 1'b1;
  logic                VDA    = 1'b0;
  logic                RESETB, PHI2, RDB, WRB, ROMCSB, RAM1CSB, RAM2CSB, WAITING;
  logic [7:0]          BA;
  logic [IO_SLOTS-1:0] IOSELB;
`ifdef CSC_EXTWAIT_EN
  logic                EXT_WAITB = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase lengths and latched bank only.
  int         m_phi2, m_left, m_elapsed;
  logic [7:0] m_ba;
  logic       m_s1, m_s2;

  csc_ws #(.CLK_DIV(CLK_DIV), .IO_SLOTS(IO_SLOTS), .ROM_WAIT(ROM_WAIT),
           .IO_WAIT(IO_WAIT), .RAM_WAIT(RAM_WAIT)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
`ifdef CSC_EXTWAIT_EN
    .EXT_WAITB(EXT_WAITB),
`endif
    .ADDR(ADDR), .DB(DB), .RWB(RWB), .VDA(VDA), .RESETB(RESETB), .BA(BA),
    .PHI2(PHI2), .RDB(RDB), .WRB(WRB), .ROMCSB(ROMCSB), .RAM1CSB(RAM1CSB),
    .RAM2CSB(RAM2CSB), .IOSELB(IOSELB), .WAITING(WAITING)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_rom(input logic [7:0] ba, input logic [15:0] a);
    return (ba >= 8'hF8) || (ba == 8'h00 && a >= 16'hF800);
  endfunction
  function automatic bit is_io(input logic [7:0] ba, input logic [15:0] a, input logic v);
    return ba == 8'h00 && a >= 16'hF000 && a < 16'hF800 && v;
  endfunction
  function automatic int wait_of(input logic [7:0] ba, input logic [15:0] a, input logic v);
    if (is_rom(ba, a)) return ROM_WAIT;
    if (is_io(ba, a, v)) return IO_WAIT;
    return RAM_WAIT;
  endfunction
  function automatic logic [IO_SLOTS-1:0] exp_iosel(input logic [7:0] ba, input logic [15:0] a,
                                                    input logic v);
    logic [IO_SLOTS-1:0] r;
    r = '1;
    if (is_io(ba, a, v)) r[(a / 32) % IO_SLOTS] = 1'b0;
    return r;
  endfunction

  task automatic step();
    logic       ext_seen;
    logic [7:0] old_ba;
    @(posedge SYSCLK);
    if (RESET) begin
      m_phi2 = 0; m_left = CLK_DIV; m_elapsed = 0; m_ba = 8'h00; m_s1 = 1'b1; m_s2 = 1'b1;
    end else begin
      ext_seen = m_s2;
      m_s2 = m_s1;
`ifdef CSC_EXTWAIT_EN
      m_s1 = EXT_WAITB;
`else
      m_s1 = 1'b1;
`endif
      old_ba = m_ba;
      if (m_phi2 == 0) m_ba = DB;
      if (m_left > 0) m_left--;
      if (m_phi2 != 0) m_elapsed++;
      if (m_left == 0 && (m_phi2 == 0 || ext_seen)) begin
        if (m_phi2 == 0) begin
          m_phi2 = 1; m_elapsed = 0; m_left = CLK_DIV + wait_of(old_ba, ADDR, VDA);
        end else begin
          m_phi2 = 0; m_left = CLK_DIV;
        end
      end
    end
    #1;
    check("PHI2", PHI2, m_phi2[0]);
    check("BA", BA, m_ba);
    check("WAITING", WAITING, (m_phi2 != 0 && m_elapsed >= CLK_DIV));
    check("RESETB", RESETB, !RESET);
    check("RDB", RDB, !(m_phi2 != 0 && RWB && !RESET));
    check("WRB", WRB, !(m_phi2 != 0 && !RWB && !RESET));
    check("ROMCSB", ROMCSB, !is_rom(m_ba, ADDR));
    check("RAM1CSB", RAM1CSB, !(m_ba < 8'h08 && !is_io(m_ba, ADDR, VDA) && !is_rom(m_ba, ADDR)));
    check("RAM2CSB", RAM2CSB, !(m_ba >= 8'h08 && m_ba < 8'h10));
    check("IOSELB", IOSELB, exp_iosel(m_ba, ADDR, VDA));
  endtask

  // Measures low length up to the rise, then high length, WAITING and strobe cycles.
  task automatic measure(output int lo, output int hi, output int wt, output int stb);
    lo = 0; hi = 0; wt = 0; stb = 0;
    while (PHI2 == 1'b0 && lo < 64) begin step(); lo++; end
    if (PHI2 == 1'b0) begin check("rise_timeout", 1, 0); return; end
    hi = 1; wt += WAITING; stb += (!RDB || !WRB);
    while (hi < 64) begin
      step();
      if (PHI2 == 1'b0) break;
      hi++; wt += WAITING; stb += (!RDB || !WRB);
    end
    if (PHI2 == 1'b1) check("fall_timeout", 1, 0);
    $display("phase ADDR=%h BA=%h lo=%0d hi=%0d wait=%0d strobe=%0d", ADDR, BA, lo, hi, wt, stb);
  endtask

  initial begin
    int lo, hi, wt, stb, n;
    m_phi2 = 0; m_left = CLK_DIV; m_elapsed = 0; m_ba = 8'h00; m_s1 = 1'b1; m_s2 = 1'b1;

    // Reset, then first rise on edge CLK_DIV with RAM timing.
    repeat (3) step();
    RESET = 1'b0;
    measure(lo, hi, wt, stb);
    check("first_rise", lo, CLK_DIV);
    check("ram_high", hi, CLK_DIV + RAM_WAIT);
    check("ram_waiting", wt, 0);
    measure(lo, hi, wt, stb);
    check("ram_low", lo, CLK_DIV);

    // Low ROM read.
    ADDR = 16'hFFFC; RWB = 1'b1;
    measure(lo, hi, wt, stb);
    check("rom_high", hi, CLK_DIV + ROM_WAIT);
    check("rom_waiting", wt, ROM_WAIT);
    check("rom_rdb", stb, CLK_DIV + ROM_WAIT);

    // I/O write, then same address without VDA.
    ADDR = 16'hF060; VDA = 1'b1; RWB = 1'b0;
    measure(lo, hi, wt, stb);
    check("io_high", hi, CLK_DIV + IO_WAIT);
    check("io_wrb", stb, CLK_DIV + IO_WAIT);
    check("io_sel", IOSELB, exp_iosel(8'h00, 16'hF060, 1'b1));
    check("io_ram1", RAM1CSB, 1'b1);
    VDA = 1'b0;
    measure(lo, hi, wt, stb);
    check("novda_high", hi, CLK_DIV + RAM_WAIT);
    check("novda_sel", IOSELB, {IO_SLOTS{1'b1}});

    // Bank latch holds through the high phase.
    ADDR = 16'h1234; RWB = 1'b1; DB = 8'h08;
    n = 0;
    while (PHI2 == 1'b0 && n < 64) begin step(); n++; end
    DB = 8'hFF;
    step();
    check("ba_hold", BA, 8'h08);
    check("ba_ram2", RAM2CSB, 1'b0);
    n = 0;
    while (PHI2 == 1'b1 && n < 64) begin step(); n++; end
    DB = 8'hF8;
    step();
    check("ba_highrom", BA, 8'hF8);
    check("highrom_cs", ROMCSB, 1'b0);
    $display("bank latch BA=%h ROMCSB=%b", BA, ROMCSB);

    // Reset on the first STRETCH cycle.
    DB = 8'h00; ADDR = 16'hFFFC;
    n = 0;
    while (WAITING == 1'b0 && n < 64) begin step(); n++; end
    check("stretch_seen", WAITING, 1'b1);
    RESET = 1'b1;
    step();
    check("rst_phi2", PHI2, 1'b0);
    check("rst_waiting", WAITING, 1'b0);
    check("rst_ba", BA, 8'h00);
    RESET = 1'b0; ADDR = 16'h0000;
    measure(lo, hi, wt, stb);
    check("rst_rise", lo, CLK_DIV);
    check("rst_high", hi, CLK_DIV + RAM_WAIT);

`ifdef CSC_EXTWAIT_EN
    // External wait held low for five edges starting with the rise edge.
    n = 0;
    while (!(m_phi2 == 0 && m_left == 1) && n < 64) begin step(); n++; end
    EXT_WAITB = 1'b0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin step(); if (PHI2) hi++; end
    EXT_WAITB = 1'b1;
    n = 0;
    while (n < 64) begin step(); n++; if (!PHI2) break; hi++; end
    check("ext_high", hi, 7);
    $display("ext wait high=%0d", hi);
`endif

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0, 1:    DB = 8'h00;
        2:       DB = $urandom_range(0, 1) ? 8'h08 : 8'hF8;
        default: DB = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0:       ADDR = 16'hFFFC;
        1:       ADDR = 16'hF000 | 16'($urandom_range(0, 16'h07FF));
        2:       ADDR = 16'hF800 | 16'($urandom_range(0, 16'h07FF));
        default: ADDR = 16'($urandom_range(0, 16'hFFFF));
      endcase
      VDA   = 1'($urandom_range(0, 1));
      RWB   = 1'($urandom_range(0, 1));
      RESET = ($urandom_range(0, 99) == 0);
`ifdef CSC_EXTWAIT_EN
      EXT_WAITB = ($urandom_range(0, 9) != 0);
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
